// File: rtl/ks_sub16_pipe.sv
// ks_sub16_pipe: two-stage Kogge-Stone subtractor, diff = a + ~b + 1.
// Valid/ready pipe with full back-pressure, borrow and overflow flags.
module ks_sub16_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  typedef struct packed {
    logic [15:0] g2;
    logic [15:4] p2;
    logic [15:0] p;
    logic        a15;
    logic        b15;
  } s1_t;

  logic [15:0] w_gen;
  logic [15:0] w_g0;
  logic [15:0] w_p0;
  logic [15:0] w_g1;
  logic [15:2] w_p1;
  logic [15:0] w_g2;
  logic [15:4] w_p2;
  logic [15:0] w_g4;
  logic [15:8] w_p4;
  logic [15:0] w_c;
  logic [15:0] w_diff;
  logic        w_bout;
  logic        w_ovf;
  logic        w_out_en;
  logic        w_s1_en;
  logic        w_in_fire;
  s1_t         w_s1_d;

  s1_t         r_s1;
  logic        r_s1_valid;
  logic [15:0] r_diff;
  logic        r_bout;
  logic        r_ovf;
  logic        r_out_valid;

  // Handshake chain: a stage may load when it is empty or draining.
  always_comb begin
    w_out_en  = ~r_out_valid | out_ready;
    w_s1_en   = ~r_s1_valid | w_out_en;
    in_ready  = w_s1_en & rst_n;
    w_in_fire = in_valid & in_ready;
  end

  // Stage 1: bit generate/propagate with carry-in folded, span-1 and span-2.
  always_comb begin
    w_gen = a & ~b;
    w_p0  = a ^ ~b;
    w_g0  = {w_gen[15:1], w_gen[0] | w_p0[0]};
    w_g1  = w_g0;
    for (int i = 1; i < 16; i++)
      w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
    w_p1 = '0;
    for (int i = 2; i < 16; i++)
      w_p1[i] = w_p0[i] & w_p0[i-1];
    w_g2 = w_g1;
    for (int i = 2; i < 16; i++)
      w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
    w_p2 = '0;
    for (int i = 4; i < 16; i++)
      w_p2[i] = w_p1[i] & w_p1[i-2];
    w_s1_d.g2  = w_g2;
    w_s1_d.p2  = w_p2;
    w_s1_d.p   = w_p0;
    w_s1_d.a15 = a[15];
    w_s1_d.b15 = b[15];
  end

  // S1 register: valid follows the input whenever the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (w_s1_en) r_s1_valid <= w_in_fire;
      if (w_in_fire) r_s1 <= w_s1_d;
    end
  end

  // Stage 2: span-4 and span-8 levels, then the sum XOR and flags.
  always_comb begin
    w_g4 = r_s1.g2;
    for (int i = 4; i < 16; i++)
      w_g4[i] = r_s1.g2[i] | (r_s1.p2[i] & r_s1.g2[i-4]);
    w_p4 = '0;
    for (int i = 8; i < 16; i++)
      w_p4[i] = r_s1.p2[i] & r_s1.p2[i-4];
    w_c = w_g4;
    for (int i = 8; i < 16; i++)
      w_c[i] = w_g4[i] | (w_p4[i] & w_g4[i-8]);
    w_diff = r_s1.p ^ {w_c[14:0], 1'b1};
    w_bout = ~w_c[15];
    w_ovf  = (r_s1.a15 ^ r_s1.b15) & (w_diff[15] ^ r_s1.a15);
  end

  // Output register: loads S1 when draining; data held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_out_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff <= w_diff;
        r_bout <= w_bout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_ks_sub16_pipe.sv
// tb_ks_sub16_pipe: directed and random checks of ks_sub16_pipe
// against an arithmetic a-b model with an in-order scoreboard.
module tb_ks_sub16_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } res_t;

  int   n_pass = 0;
  int   n_chk  = 0;
  res_t q[$];

  ks_sub16_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
    int   sd;
    res_t r;
    sd   = int'($signed(x)) - int'($signed(y));
    r.d  = x - y;
    r.bo = (x < y);
    r.ov = (sd > 32767) || (sd < -32768);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Scoreboard: inputs stable from posedge+1 to next posedge, so the
  // negedge sees exactly the handshake that the next edge will perform.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else begin
          check("stream", 32'({diff, bout, ovf}), 32'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b));
    end
  end

  task automatic direct(input string nm, input logic [15:0] x,
                        input logic [15:0] y, input res_t exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({nm, "_lat2"}, 32'(out_valid), 32'd1);
    check(nm, 32'({diff, bout, ovf}), 32'(exp));
  endtask

  logic [15:0] sa [5] = '{16'h0010, 16'h1234, 16'h0000, 16'h8000, 16'hFFFF};
  logic [15:0] sb [5] = '{16'h0001, 16'h0234, 16'h0005, 16'h7FFF, 16'hFFFF};

  initial begin
    int   sent;
    logic fire;
    logic [15:0] hold;

    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({bout, ovf}), 32'd0);

    check("pin_5_3", 32'(model(16'h0005, 16'h0003)), 32'({16'h0002, 2'b00}));
    check("pin_0_1", 32'(model(16'h0000, 16'h0001)), 32'({16'hFFFF, 2'b10}));
    check("pin_8000_1", 32'(model(16'h8000, 16'h0001)), 32'({16'h7FFF, 2'b01}));
    check("pin_7fff_ffff", 32'(model(16'h7FFF, 16'hFFFF)), 32'({16'h8000, 2'b11}));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    direct("basic", 16'h0005, 16'h0003, '{16'h0002, 1'b0, 1'b0});
    direct("borrow", 16'h0000, 16'h0001, '{16'hFFFF, 1'b1, 1'b0});
    direct("ovf_neg", 16'h8000, 16'h0001, '{16'h7FFF, 1'b0, 1'b1});
    direct("ovf_pos", 16'h7FFF, 16'hFFFF, '{16'h8000, 1'b1, 1'b1});
    direct("equal", 16'hA5A5, 16'hA5A5, '{16'h0000, 1'b0, 1'b0});
    @(posedge clk); #1;

    // Back-pressure: out_ready low for the first 4 cycles of a 5-op stream.
    out_ready = 1'b0;
    sent = 0;
    hold = '0;
    for (int cyc = 0; cyc < 60 && sent < 5; cyc++) begin
      if (cyc == 4) out_ready = 1'b1;
      in_valid = 1'b1;
      a = sa[sent];
      b = sb[sent];
      #1;
      if (cyc == 2) begin
        check("bp_ready_low", 32'(in_ready), 32'd0);
        hold = diff;
      end
      if (cyc == 3) check("bp_hold_diff", 32'(diff), 32'(hold));
      if (cyc == 4) check("bp_ready_ret", 32'(in_ready), 32'd1);
      fire = in_ready;
      @(posedge clk); #1;
      if (fire) sent++;
    end
    in_valid = 1'b0;
    check("bp_sent", sent, 32'd5);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1 check("bp_drained", 32'(q.size()), 32'd0);

    // Reset with two results in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h0F00;
    b = 16'h0001;
    @(posedge clk); #1;
    a = 16'h1111;
    b = 16'h0110;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_flags", 32'({bout, ovf}), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("no_stale", 32'(out_valid), 32'd0);

    // Random traffic under random valid/ready.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1 check("rand_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
